rob_multiport: RTL and testbench

//  Parametrised reorder buffer for the out-of-order RV32I core. Holds up to DEPTH in-flight

---
 rtl/rob_multiport.sv | 178 +++++++++++++++++
 tb/tb_rob_multiport.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rob_multiport.sv
// Reorder buffer: in-order dispatch, NUM_WB out-of-order result channels, in-order retire
// with flush on a committed mispredict. Per-entry state lives in an array of rob_entry.
module rob_entry #(
  parameter int NUM_WB = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc,
  input  logic                   retire,
  input  logic [31:0]            alloc_pc,
  input  logic [4:0]             alloc_rd,
  input  logic [NUM_WB-1:0]      wb_hit,
  input  logic [NUM_WB-1:0][31:0] wb_data,
  input  logic [NUM_WB-1:0][31:0] wb_target,
  input  logic [NUM_WB-1:0]      wb_misp,
  output logic                   valid,
  output logic                   ready,
  output logic                   misp,
  output logic [31:0]            pc,
  output logic [4:0]             rd,
  output logic [31:0]            data,
  output logic [31:0]            target
);
  logic        sel_any, sel_misp;
  logic [31:0] sel_data, sel_tgt;

  // Scan high to low so the lowest-index channel overrides on a collision
  always_comb begin
    sel_any  = 1'b0;
    sel_misp = 1'b0;
    sel_data = '0;
    sel_tgt  = '0;
    for (int j = NUM_WB-1; j >= 0; j--) begin
      if (wb_hit[j]) begin
        sel_any  = 1'b1;
        sel_misp = wb_misp[j];
        sel_data = wb_data[j];
        sel_tgt  = wb_target[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      ready  <= 1'b0;
      misp   <= 1'b0;
      pc     <= '0;
      rd     <= '0;
      data   <= '0;
      target <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ready <= 1'b0;
      misp  <= 1'b0;
    end else if (alloc) begin
      valid <= 1'b1;
      ready <= 1'b0;
      misp  <= 1'b0;
      pc    <= alloc_pc;
      rd    <= alloc_rd;
    end else begin
      if (sel_any && valid) begin
        ready  <= 1'b1;
        misp   <= sel_misp;
        data   <= sel_data;
        target <= sel_tgt;
      end
      if (retire) begin
        valid <= 1'b0;
        ready <= 1'b0;
      end
    end
  end
endmodule

module rob_multiport #(
  parameter int DEPTH  = 16,
  parameter int NUM_WB = 3,
  localparam int ID_W  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  input  logic [31:0]            dispatch_pc,
  input  logic [4:0]             dispatch_rd_addr,
  output logic                   dispatch_ready,
  output logic [ID_W-1:0]        dispatch_rob_id,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*ID_W-1:0] wb_rob_id,
  input  logic [NUM_WB*32-1:0]   wb_rd_data,
  input  logic [NUM_WB-1:0]      wb_mispredict,
  input  logic [NUM_WB*32-1:0]   wb_target,
  output logic                   commit_valid,
  output logic [ID_W-1:0]        commit_rob_id,
  output logic [31:0]            commit_pc,
  output logic [4:0]             commit_rd_addr,
  output logic [31:0]            commit_rd_data,
  output logic                   commit_regf_we,
  output logic                   flush_valid,
  output logic [31:0]            flush_pc
);
  logic [ID_W:0]   head, tail, count;
  logic [ID_W-1:0] hidx, tidx;
  logic            full, empty, dispatch_fire;

  logic [NUM_WB-1:0][ID_W-1:0] wb_id_v;
  logic [NUM_WB-1:0][31:0]     wb_data_v, wb_tgt_v;

  logic [DEPTH-1:0]             e_valid, e_ready, e_misp;
  logic [DEPTH-1:0][31:0]       e_pc, e_data, e_tgt;
  logic [DEPTH-1:0][4:0]        e_rd;
  logic [DEPTH-1:0][NUM_WB-1:0] wb_hit;

  assign wb_id_v   = wb_rob_id;
  assign wb_data_v = wb_rd_data;
  assign wb_tgt_v  = wb_target;

  assign hidx  = head[ID_W-1:0];
  assign tidx  = tail[ID_W-1:0];
  assign count = tail - head;
  assign full  = (count == (ID_W+1)'(DEPTH));
  assign empty = (count == '0);

  assign commit_valid    = !empty && e_valid[hidx] && e_ready[hidx];
  assign flush_valid     = commit_valid && e_misp[hidx];
  assign dispatch_ready  = !full && !flush_valid;
  assign dispatch_fire   = dispatch_valid && dispatch_ready;
  assign dispatch_rob_id = tidx;

  assign commit_rob_id  = commit_valid ? hidx        : '0;
  assign commit_pc      = commit_valid ? e_pc[hidx]  : '0;
  assign commit_rd_addr = commit_valid ? e_rd[hidx]  : '0;
  assign commit_rd_data = commit_valid ? e_data[hidx] : '0;
  assign commit_regf_we = commit_valid && (e_rd[hidx] != 5'd0);
  assign flush_pc       = flush_valid ? e_tgt[hidx] : '0;

  genvar i, j;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      for (j = 0; j < NUM_WB; j++) begin : g_hit
        assign wb_hit[i][j] = wb_valid[j] && (wb_id_v[j] == ID_W'(i));
      end
      rob_entry #(.NUM_WB(NUM_WB)) u_ent (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_valid),
        .alloc    (dispatch_fire && (tidx == ID_W'(i))),
        .retire   (commit_valid && (hidx == ID_W'(i))),
        .alloc_pc (dispatch_pc),
        .alloc_rd (dispatch_rd_addr),
        .wb_hit   (wb_hit[i]),
        .wb_data  (wb_data_v),
        .wb_target(wb_tgt_v),
        .wb_misp  (wb_mispredict),
        .valid    (e_valid[i]),
        .ready    (e_ready[i]),
        .misp     (e_misp[i]),
        .pc       (e_pc[i]),
        .rd       (e_rd[i]),
        .data     (e_data[i]),
        .target   (e_tgt[i])
      );
    end
  endgenerate

  // Flush rewinds both pointers; anything dispatched that cycle is dropped
  always_ff @(posedge clk) begin
    if (rst || flush_valid) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (dispatch_fire) tail <= tail + 1'b1;
      if (commit_valid)  head <= head + 1'b1;
    end
  end
endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport (DEPTH=16, NUM_WB=3): fill, out-of-order wb,
// multi-channel wb, flush, full-with-commit and pointer wrap.
module tb_rob_multiport;
  localparam int DEPTH = 16, NUM_WB = 3, ID_W = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic dispatch_valid = 1'b0;
  logic [31:0] dispatch_pc = '0;
  logic [4:0]  dispatch_rd_addr = '0;
  logic dispatch_ready;
  logic [ID_W-1:0] dispatch_rob_id;
  logic [NUM_WB-1:0] wb_valid = '0, wb_misp = '0;
  logic [NUM_WB-1:0][ID_W-1:0] wb_id = '0;
  logic [NUM_WB-1:0][31:0] wb_data = '0, wb_tgt = '0;
  logic commit_valid, commit_regf_we, flush_valid;
  logic [ID_W-1:0] commit_rob_id;
  logic [31:0] commit_pc, commit_rd_data, flush_pc;
  logic [4:0] commit_rd_addr;

  int errors = 0, checks = 0;
  logic [31:0] exp_pc [DEPTH];

  always #5 clk = ~clk;

  rob_multiport #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_pc(dispatch_pc),
    .dispatch_rd_addr(dispatch_rd_addr), .dispatch_ready(dispatch_ready),
    .dispatch_rob_id(dispatch_rob_id),
    .wb_valid(wb_valid), .wb_rob_id(wb_id), .wb_rd_data(wb_data),
    .wb_mispredict(wb_misp), .wb_target(wb_tgt),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_pc(commit_pc),
    .commit_rd_addr(commit_rd_addr), .commit_rd_data(commit_rd_data),
    .commit_regf_we(commit_regf_we), .flush_valid(flush_valid), .flush_pc(flush_pc)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    dispatch_valid = 1'b0; wb_valid = '0; wb_misp = '0;
  endtask

  task automatic do_reset();
    clr(); rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic disp(input logic [31:0] pc, input logic [4:0] rd);
    dispatch_valid = 1'b1; dispatch_pc = pc; dispatch_rd_addr = rd;
    tick(); dispatch_valid = 1'b0;
  endtask

  task automatic set_wb(input int ch, input int id, input logic [31:0] d,
                        input logic m, input logic [31:0] t);
    wb_valid[ch] = 1'b1; wb_id[ch] = ID_W'(id); wb_data[ch] = d;
    wb_misp[ch] = m; wb_tgt[ch] = t;
  endtask

  task automatic test_reset();
    do_reset(); tick();
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", dispatch_ready); end
    checks++; if (dispatch_rob_id !== 4'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", dispatch_rob_id); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit got %b exp 0", commit_valid); end
    checks++; if (flush_valid !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush_valid); end
    checks++; if ({commit_pc, commit_rd_data, flush_pc, commit_regf_we} !== '0) begin errors++; $display("FAIL reset_outs got nonzero exp 0"); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      checks++; if (dispatch_ready !== 1'b1 || dispatch_rob_id !== 4'(k)) begin
        errors++; $display("FAIL fill_id got rdy=%b id=%0d exp rdy=1 id=%0d", dispatch_ready, dispatch_rob_id, k); end
      disp(32'h1000 + 32'(4*k), 5'(k+1));
    end
    checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %b exp 0", dispatch_ready); end
    dispatch_valid = 1'b1; dispatch_pc = 32'h2000; dispatch_rd_addr = 5'd7;
    tick(); clr();
    checks++; if (dispatch_ready !== 1'b0 || commit_valid !== 1'b0) begin
      errors++; $display("FAIL fill_17th got rdy=%b cv=%b exp 0 0", dispatch_ready, commit_valid); end
    set_wb(0, 0, 32'h55, 1'b0, 32'h0); tick(); clr();
    checks++; if (commit_valid !== 1'b1 || commit_pc !== 32'h1000 || commit_rd_addr !== 5'd1) begin
      errors++; $display("FAIL fill_head got cv=%b pc=%h rd=%0d exp 1 1000 1", commit_valid, commit_pc, commit_rd_addr); end
  endtask

  task automatic test_ooo_wb();
    do_reset();
    disp(32'h100, 5'd1); disp(32'h104, 5'd2); disp(32'h108, 5'd3);
    set_wb(0, 2, 32'h22, 1'b0, 0); tick(); clr();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_after_id2 got %b exp 0", commit_valid); end
    set_wb(1, 1, 32'h11, 1'b0, 0); tick(); clr();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_after_id1 got %b exp 0", commit_valid); end
    set_wb(2, 0, 32'h00, 1'b0, 0); tick(); clr();
    for (int k = 0; k < 3; k++) begin
      checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'(k) || commit_rd_data !== 32'(k*'h11)
                    || commit_pc !== 32'h100 + 32'(4*k)) begin
        errors++; $display("FAIL ooo_commit%0d got cv=%b id=%0d d=%h pc=%h exp 1 %0d %h %h", k, commit_valid,
                           commit_rob_id, commit_rd_data, commit_pc, k, k*'h11, 32'h100 + 32'(4*k)); end
      tick();
    end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_drained got %b exp 0", commit_valid); end
  endtask

  task automatic test_multi_wb();
    do_reset();
    for (int i = 0; i < 7; i++) disp(32'h400 + 32'(4*i), (i == 3) ? 5'd0 : 5'(i+1));
    set_wb(0, 0, 32'hA0, 0, 0); set_wb(1, 1, 32'hA1, 0, 0); set_wb(2, 2, 32'hA2, 0, 0);
    tick(); clr();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) set_wb(2, 3, 32'hA3, 0, 0);
      if (k == 1) begin set_wb(0, 4, 32'hA4, 0, 0); set_wb(1, 5, 32'hA5, 0, 0); set_wb(2, 6, 32'hA6, 0, 0); end
      checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'(k) || commit_rd_data !== 32'hA0 + 32'(k)
                    || commit_regf_we !== (k != 3)) begin
        errors++; $display("FAIL multi_commit%0d got cv=%b id=%0d d=%h we=%b exp 1 %0d %h %b", k, commit_valid,
                           commit_rob_id, commit_rd_data, commit_regf_we, k, 32'hA0 + 32'(k), k != 3); end
      tick(); clr();
    end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL multi_drained got %b exp 0", commit_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 8; i++) disp(32'h200 + 32'(4*i), 5'(i+1));
    set_wb(0, 0, 32'h30, 0, 0); set_wb(1, 1, 32'h31, 0, 0); set_wb(2, 2, 32'h32, 0, 0);
    tick(); clr();
    set_wb(0, 3, 32'h33, 1'b1, 32'h8000); tick(); clr();
    tick();
    checks++; if (commit_rob_id !== 4'd2 || flush_valid !== 1'b0) begin
      errors++; $display("FAIL flush_pre got id=%0d fv=%b exp 2 0", commit_rob_id, flush_valid); end
    tick();
    dispatch_valid = 1'b1; dispatch_pc = 32'hDEAD; dispatch_rd_addr = 5'd9;
    set_wb(1, 4, 32'h44, 0, 0);
    checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'd3 || flush_valid !== 1'b1 || flush_pc !== 32'h8000
                  || commit_regf_we !== 1'b1 || commit_rd_data !== 32'h33 || dispatch_ready !== 1'b0) begin
      errors++; $display("FAIL flush_commit got cv=%b id=%0d fv=%b fpc=%h we=%b d=%h rdy=%b exp 1 3 1 8000 1 33 0",
                         commit_valid, commit_rob_id, flush_valid, flush_pc, commit_regf_we, commit_rd_data, dispatch_ready); end
    tick(); clr();
    checks++; if (commit_valid !== 1'b0 || flush_valid !== 1'b0 || dispatch_ready !== 1'b1 || dispatch_rob_id !== 4'd0) begin
      errors++; $display("FAIL flush_after got cv=%b fv=%b rdy=%b id=%0d exp 0 0 1 0", commit_valid, flush_valid,
                         dispatch_ready, dispatch_rob_id); end
    set_wb(1, 5, 32'h99, 0, 0); tick(); clr();
    checks++; if (commit_valid !== 1'b0 || dispatch_rob_id !== 4'd0) begin
      errors++; $display("FAIL flush_stale_wb got cv=%b id=%0d exp 0 0", commit_valid, dispatch_rob_id); end
    disp(32'h300, 5'd2);
    set_wb(0, 0, 32'h77, 0, 0); tick(); clr();
    checks++; if (commit_valid !== 1'b1 || commit_pc !== 32'h300 || commit_rd_data !== 32'h77) begin
      errors++; $display("FAIL flush_restart got cv=%b pc=%h d=%h exp 1 300 77", commit_valid, commit_pc, commit_rd_data); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin exp_pc[i] = 32'h4000 + 32'(4*i); disp(exp_pc[i], 5'((i & 15) + 1)); end
    set_wb(0, 0, 32'hD0, 0, 0); tick(); clr();
    dispatch_valid = 1'b1; dispatch_pc = 32'h5000; dispatch_rd_addr = 5'd3;
    checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'd0 || dispatch_ready !== 1'b0) begin
      errors++; $display("FAIL full_same_cycle got cv=%b id=%0d rdy=%b exp 1 0 0", commit_valid, commit_rob_id, dispatch_ready); end
    tick();
    checks++; if (dispatch_ready !== 1'b1 || dispatch_rob_id !== 4'd0 || commit_valid !== 1'b0) begin
      errors++; $display("FAIL full_next got rdy=%b id=%0d cv=%b exp 1 0 0", dispatch_ready, dispatch_rob_id, commit_valid); end
    tick(); clr(); exp_pc[0] = 32'h5000;
    checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL full_again got %b exp 0", dispatch_ready); end
    set_wb(0, 1, 32'hD1, 0, 0); tick(); clr(); tick();
    for (int k = 0; k < 40; k++) begin
      set_wb(k % 3, (2 + k) % 16, 32'hE000 + 32'(k), 0, 0);
      dispatch_valid = 1'b1; dispatch_pc = 32'h6000 + 32'(4*k); dispatch_rd_addr = 5'd5;
      checks++; if (dispatch_ready !== 1'b1 || dispatch_rob_id !== 4'((1 + k) % 16) || commit_valid !== 1'b0) begin
        errors++; $display("FAIL wrap_alloc%0d got rdy=%b id=%0d cv=%b exp 1 %0d 0", k, dispatch_ready, dispatch_rob_id,
                           commit_valid, (1 + k) % 16); end
      tick(); clr();
      exp_pc[(1 + k) % 16] = 32'h6000 + 32'(4*k);
      checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'((2 + k) % 16) || commit_pc !== exp_pc[(2 + k) % 16]
                    || commit_rd_data !== 32'hE000 + 32'(k) || dispatch_ready !== 1'b0) begin
        errors++; $display("FAIL wrap_commit%0d got cv=%b id=%0d pc=%h d=%h rdy=%b exp 1 %0d %h %h 0", k, commit_valid,
                           commit_rob_id, commit_pc, commit_rd_data, dispatch_ready, (2 + k) % 16,
                           exp_pc[(2 + k) % 16], 32'hE000 + 32'(k)); end
      tick();
    end
    checks++; if (dispatch_ready !== 1'b1 || commit_valid !== 1'b0 || dispatch_rob_id !== 4'd9) begin
      errors++; $display("FAIL wrap_end got rdy=%b cv=%b id=%0d exp 1 0 9", dispatch_ready, commit_valid, dispatch_rob_id); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ooo_wb();
    test_multi_wb();
    test_flush();
    test_full_wrap();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (commit_valid !== 1'b0 || dispatch_rob_id !== 4'd0 || dispatch_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got cv=%b id=%0d rdy=%b exp 0 0 1", commit_valid, dispatch_rob_id, dispatch_ready); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
